// File: rtl/simple_cpu_sequencer.sv
// Fetch/decode/execute sequencer for the simple 8-bit CPU; drives the program ROM address.
// Optional carry flag output: define SIMPLE_CPU_CARRY_FLAG_EN.
module simple_cpu_sequencer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    output logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] ac,
    output logic [1:0]            opcode,
    output logic [3:0]            state,
`ifdef SIMPLE_CPU_CARRY_FLAG_EN
    output logic                  carry,
`endif
    output logic                  instr_done
);

    typedef enum logic [3:0] {
        FETCH1 = 4'd0,
        FETCH2 = 4'd1,
        FETCH3 = 4'd2,
        ADD1   = 4'd3,
        ADD2   = 4'd4,
        AND1   = 4'd5,
        AND2   = 4'd6,
        JMP1   = 4'd7,
        INC1   = 4'd8
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] ar_q;
    logic [DATA_WIDTH-1:0] dr_q;
    logic [DATA_WIDTH-1:0] ac_q;
    logic [1:0]            ir_q;
`ifdef SIMPLE_CPU_CARRY_FLAG_EN
    logic                  carry_q;
`endif

    // Sequencer FSM and datapath registers; reset aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH1;
            pc_q    <= '0;
            ar_q    <= '0;
            dr_q    <= '0;
            ac_q    <= '0;
            ir_q    <= '0;
`ifdef SIMPLE_CPU_CARRY_FLAG_EN
            carry_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                FETCH1: begin
                    if (run) begin
                        ar_q    <= pc_q;
                        state_q <= FETCH2;
                    end
                end
                FETCH2: begin
                    dr_q    <= instruction;
                    pc_q    <= pc_q + ADDR_WIDTH'(1);
                    state_q <= FETCH3;
                end
                FETCH3: begin
                    ir_q <= dr_q[DATA_WIDTH-1 -: 2];
                    ar_q <= dr_q[ADDR_WIDTH-1:0];
                    case (dr_q[DATA_WIDTH-1 -: 2])
                        2'b00:   state_q <= ADD1;
                        2'b01:   state_q <= AND1;
                        2'b10:   state_q <= JMP1;
                        default: state_q <= INC1;
                    endcase
                end
                ADD1: begin
                    dr_q    <= instruction;
                    state_q <= ADD2;
                end
                ADD2: begin
`ifdef SIMPLE_CPU_CARRY_FLAG_EN
                    {carry_q, ac_q} <= {1'b0, ac_q} + {1'b0, dr_q};
`else
                    ac_q <= ac_q + dr_q;
`endif
                    state_q <= FETCH1;
                end
                AND1: begin
                    dr_q    <= instruction;
                    state_q <= AND2;
                end
                AND2: begin
                    ac_q    <= ac_q & dr_q;
                    state_q <= FETCH1;
                end
                JMP1: begin
                    pc_q    <= dr_q[ADDR_WIDTH-1:0];
                    state_q <= FETCH1;
                end
                INC1: begin
`ifdef SIMPLE_CPU_CARRY_FLAG_EN
                    carry_q <= (ac_q == '1);
`endif
                    ac_q    <= ac_q + DATA_WIDTH'(1);
                    state_q <= FETCH1;
                end
                default: begin
                    state_q <= FETCH1;
                end
            endcase
        end
    end

    // Completion pulse decoded from the final execute states, masked while reset is asserted.
    always_comb begin
        instr_done = 1'b0;
        if (!rst) begin
            instr_done = (state_q == ADD2) || (state_q == AND2) ||
                         (state_q == JMP1) || (state_q == INC1);
        end
    end

    assign address = ar_q;
    assign pc      = pc_q;
    assign ac      = ac_q;
    assign opcode  = ir_q;
    assign state   = state_q;
`ifdef SIMPLE_CPU_CARRY_FLAG_EN
    assign carry   = carry_q;
`endif

endmodule

// File: tb/tb_simple_cpu_sequencer.sv
// Testbench for simple_cpu_sequencer: directed program steps plus a completion scoreboard.
module tb_simple_cpu_sequencer;

    logic       clk;
    logic       rst;
    logic       run;
    logic [5:0] address;
    logic [7:0] instruction;
    logic [5:0] pc;
    logic [7:0] ac;
    logic [1:0] opcode;
    logic [3:0] state;
    logic       instr_done;
`ifdef SIMPLE_CPU_CARRY_FLAG_EN
    logic       carry;
`endif

    logic [7:0] rom [64];

    typedef struct {
        logic [7:0] ac;
        logic [5:0] pc;
        logic       carry;
    } exp_t;

    exp_t sb [$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   pend  = 0;

    localparam logic [3:0] S_FETCH1 = 4'd0;
    localparam logic [3:0] S_ADD1   = 4'd3;
    localparam logic [3:0] S_ADD2   = 4'd4;
    localparam logic [3:0] S_AND1   = 4'd5;
    localparam logic [3:0] S_AND2   = 4'd6;
    localparam logic [3:0] S_JMP1   = 4'd7;
    localparam logic [3:0] S_INC1   = 4'd8;

    simple_cpu_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .address     (address),
        .instruction (instruction),
        .pc          (pc),
        .ac          (ac),
        .opcode      (opcode),
        .state       (state),
`ifdef SIMPLE_CPU_CARRY_FLAG_EN
        .carry       (carry),
`endif
        .instr_done  (instr_done)
    );

    assign instruction = rom[address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            hit = (state === s);
        end
        chk(tag, 32'(hit), 32'd1);
    endtask

    task automatic push(input logic [7:0] a, input logic [5:0] p, input logic c);
        exp_t e;
        e.ac    = a;
        e.pc    = p;
        e.carry = c;
        sb.push_back(e);
    endtask

    // Scoreboard: one cycle after each completion pulse the architectural state must match.
    always @(negedge clk) begin
        exp_t e;
        if (pend) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_done", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk("sb_ac", 32'(ac), 32'(e.ac));
                chk("sb_pc", 32'(pc), 32'(e.pc));
`ifdef SIMPLE_CPU_CARRY_FLAG_EN
                chk("sb_carry", 32'(carry), 32'(e.carry));
`endif
            end
        end
        pend = (instr_done === 1'b1);
    end

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 8'h00;
        rom[0] = 8'hC0;
        rom[1] = 8'h80;
        rst = 1'b1;
        run = 1'b1;

        // Reset held two cycles with run high
        tick(2);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_ac", 32'(ac), 32'd0);
        chk("rst_addr", 32'(address), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_done", 32'(instr_done), 32'd0);

        // INC/JMP loop: 4 iterations of 8 cycles
        for (int k = 1; k <= 4; k++) begin
            push(8'(k), 6'd1, 1'b0);
            push(8'(k), 6'd0, 1'b0);
        end
        rst = 1'b0;
        tick(2);
        chk("inc_done_early", 32'(instr_done), 32'd0);
        tick(1);
        chk("inc_state", 32'(state), 32'(S_INC1));
        chk("inc_done", 32'(instr_done), 32'd1);
        tick(1);
        chk("inc_ac_c4", 32'(ac), 32'd1);
        chk("inc_pc_c4", 32'(pc), 32'd1);
        chk("inc_opcode", 32'(opcode), 32'd3);
        chk("inc_done_clr", 32'(instr_done), 32'd0);
        tick(3);
        chk("jmp_state", 32'(state), 32'(S_JMP1));
        chk("jmp_pc_pre", 32'(pc), 32'd2);
        chk("jmp_done", 32'(instr_done), 32'd1);
        tick(1);
        chk("jmp_pc", 32'(pc), 32'd0);
        chk("jmp_state_f1", 32'(state), 32'(S_FETCH1));
        tick(24);
        chk("loop_ac32", 32'(ac), 32'd4);
        chk("loop_pc32", 32'(pc), 32'd0);

        // Run stall after reset
        rst = 1'b1;
        run = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(10);
        chk("stall_state", 32'(state), 32'(S_FETCH1));
        chk("stall_pc", 32'(pc), 32'd0);
        chk("stall_ac", 32'(ac), 32'd0);

        // Program: JMP 8, 15x INC, JMP 2, ADD 5, AND 5, ADD 30, INC(F3), INC, ADD 5
        for (int i = 0; i < 64; i++) rom[i] = 8'h00;
        rom[0] = 8'h88;
        for (int i = 8; i <= 22; i++) rom[i] = 8'hC0;
        rom[23] = 8'h82;
        rom[2]  = 8'h05;
        rom[3]  = 8'h45;
        rom[4]  = 8'h1E;
        rom[5]  = 8'hF3;
        rom[6]  = 8'hC0;
        rom[7]  = 8'h05;
        rom[30] = 8'hFD;
        push(8'h00, 6'd8, 1'b0);
        for (int k = 1; k <= 15; k++) push(8'(k), 6'(8 + k), 1'b0);
        push(8'h0F, 6'd2, 1'b0);
        push(8'h02, 6'd3, 1'b1);
        push(8'h02, 6'd4, 1'b1);
        push(8'hFF, 6'd5, 1'b0);
        push(8'h00, 6'd6, 1'b1);
        push(8'h01, 6'd7, 1'b0);

        // ADD with run dropped in ADD1
        run = 1'b1;
        wait_state(S_ADD1, 300, "wait_add1");
        chk("add1_ac_pre", 32'(ac), 32'h0F);
        run = 1'b0;
        tick(1);
        chk("add2_state", 32'(state), 32'(S_ADD2));
        chk("add2_done", 32'(instr_done), 32'd1);
        tick(1);
        chk("add_ac", 32'(ac), 32'h02);
        chk("add_state_f1", 32'(state), 32'(S_FETCH1));
`ifdef SIMPLE_CPU_CARRY_FLAG_EN
        chk("add_carry", 32'(carry), 32'd1);
`endif
        tick(3);
        chk("park_state", 32'(state), 32'(S_FETCH1));
        chk("park_pc", 32'(pc), 32'd3);
        chk("park_addr", 32'(address), 32'd5);

        // AND 5
        run = 1'b1;
        wait_state(S_AND1, 20, "wait_and1");
        run = 1'b0;
        tick(1);
        chk("and2_state", 32'(state), 32'(S_AND2));
        chk("and2_done", 32'(instr_done), 32'd1);
        tick(1);
        chk("and_ac", 32'(ac), 32'h02);
        tick(2);
        chk("and_park", 32'(state), 32'(S_FETCH1));
        chk("and_pc", 32'(pc), 32'd4);

        // ADD 30 brings AC to FF, then INC wraps it
        run = 1'b1;
        wait_state(S_INC1, 40, "wait_inc_wrap");
        chk("wrap_ac_pre", 32'(ac), 32'hFF);
        chk("wrap_done", 32'(instr_done), 32'd1);
        run = 1'b0;
        tick(1);
        chk("wrap_ac", 32'(ac), 32'h00);
`ifdef SIMPLE_CPU_CARRY_FLAG_EN
        chk("wrap_carry", 32'(carry), 32'd1);
`endif

        // INC then reset asserted during ADD1
        run = 1'b1;
        wait_state(S_ADD1, 40, "wait_add1_rst");
        chk("rst_mid_ac_pre", 32'(ac), 32'h01);
        rst = 1'b1;
        tick(1);
        chk("rst_mid_state", 32'(state), 32'(S_FETCH1));
        chk("rst_mid_pc", 32'(pc), 32'd0);
        chk("rst_mid_ac", 32'(ac), 32'd0);
        chk("rst_mid_addr", 32'(address), 32'd0);
        chk("rst_mid_opcode", 32'(opcode), 32'd0);
        chk("rst_mid_done", 32'(instr_done), 32'd0);
        run = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(3);
        chk("post_rst_ac", 32'(ac), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
